muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide.
// Fixed latency of 32 iterations plus one DONE cycle for every operation.
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic            r_neg;
    logic            r_div0;
    logic            r_ovf;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;

    // Operand decode at acceptance: signedness, magnitudes, special cases
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic [W-1:0]    w_mag_a;
    logic [W-1:0]    w_mag_b;
    logic            w_div0;
    logic            w_ovf;
    logic            w_neg;

    always_comb begin
        w_a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        w_b_signed = op[2] ? ~op[0] : ~op[1];
        w_sa       = w_a_signed & operand_a[W-1];
        w_sb       = w_b_signed & operand_b[W-1];
        w_mag_a    = w_sa ? (~operand_a + W'(1)) : operand_a;
        w_mag_b    = w_sb ? (~operand_b + W'(1)) : operand_b;
        w_div0     = (operand_b == '0);
        w_ovf      = op[2] & ~op[0] & (operand_a == {1'b1, {(W-1){1'b0}}}) & (&operand_b);
        // Remainder takes the dividend's sign; everything else takes sign(a)^sign(b)
        w_neg      = (op[2] & op[1]) ? w_sa : (w_sa ^ w_sb);
    end

    // One iteration of shift-add multiply or restoring divide
    logic [W:0]      w_mul_sum;
    logic [W:0]      w_shift;
    logic [W:0]      w_diff;
    logic            w_ge;
    logic [W-1:0]    w_hi_nxt;
    logic [W-1:0]    w_lo_nxt;

    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_x} : '0);
        w_shift   = {r_hi, r_lo[W-1]};
        w_diff    = w_shift - {1'b0, r_x};
        w_ge      = (w_shift >= {1'b0, r_x});
        if (r_op[2]) begin
            w_hi_nxt = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
            w_lo_nxt = {r_lo[W-2:0], w_ge};
        end else begin
            w_hi_nxt = w_mul_sum[W:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[W-1:1]};
        end
    end

    // Final sign fix-up and result selection from the last iteration
    logic [2*W-1:0]  w_prod;
    logic [2*W-1:0]  w_prod_s;
    logic [W-1:0]    w_quot;
    logic [W-1:0]    w_rem;
    logic [W-1:0]    w_final;

    always_comb begin
        w_prod   = {w_hi_nxt, w_lo_nxt};
        w_prod_s = r_neg ? (~w_prod + (2*W)'(1)) : w_prod;
        w_quot   = r_neg ? (~w_lo_nxt + W'(1)) : w_lo_nxt;
        w_rem    = r_neg ? (~w_hi_nxt + W'(1)) : w_hi_nxt;
        if (r_div0) begin
            w_quot = '1;
            w_rem  = r_a;
        end else if (r_ovf) begin
            w_quot = {1'b1, {(W-1){1'b0}}};
            w_rem  = '0;
        end
        if (r_op[2]) begin
            w_final = r_op[1] ? w_rem : w_quot;
        end else begin
            w_final = (r_op[1:0] == 2'b00) ? w_prod_s[W-1:0] : w_prod_s[2*W-1:W];
        end
    end

    // Control FSM and datapath registers; flush overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_op         <= '0;
            r_neg        <= 1'b0;
            r_div0       <= 1'b0;
            r_ovf        <= 1'b0;
            r_a          <= '0;
            r_x          <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else if (flush) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    result_valid <= 1'b0;
                    if (start) begin
                        r_state <= S_CALC;
                        busy    <= 1'b1;
                        r_cnt   <= '0;
                        r_op    <= op;
                        r_neg   <= w_neg;
                        r_div0  <= op[2] & w_div0;
                        r_ovf   <= w_ovf;
                        r_a     <= operand_a;
                        r_hi    <= '0;
                        r_x     <= op[2] ? w_mag_b : w_mag_a;
                        r_lo    <= op[2] ? w_mag_a : w_mag_b;
                    end
                end
                S_CALC: begin
                    r_hi <= w_hi_nxt;
                    r_lo <= w_lo_nxt;
                    if (r_cnt == LAST_ITER) begin
                        r_state      <= S_DONE;
                        r_cnt        <= '0;
                        result_valid <= 1'b1;
                        result       <= w_final;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    int n_total;
    int n_bad;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV32M semantics computed with plain 64-bit arithmetic
    function automatic logic [31:0] ref_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int          ia;
        int          ib;
        longint      la;
        longint      lb;
        logic [63:0] p;
        logic [31:0] r;
        ia = $signed(a);
        ib = $signed(b);
        la = ia;
        r  = '0;
        case (o)
            3'd0, 3'd1: begin
                lb = ib;
                p  = 64'(la * lb);
                r  = (o == 3'd0) ? p[31:0] : p[63:32];
            end
            3'd2: begin
                lb = longint'({32'd0, b});
                p  = 64'(la * lb);
                r  = p[63:32];
            end
            3'd3: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[63:32];
            end
            3'd4: begin
                if (b == 32'd0)                                r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else                                           r = 32'(ia / ib);
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0)                                r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else                                           r = 32'(ia % ib);
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one op from IDLE, scramble inputs after accept, and check latency, pulse count and value
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int          first;
        int          pulses;
        logic [31:0] got;
        logic [31:0] exp;
        exp       = ref_calc(o, a, b);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        start     = 1'b0;
        op        = 3'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
        first  = 0;
        pulses = 0;
        got    = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (result_valid) begin
                pulses++;
                if (first == 0) begin
                    first = k;
                    got   = result;
                end
            end
            if (k == 33) chk({tag, "_idle"}, 32'(busy), 32'd0);
        end
        chk({tag, "_lat"}, 32'(first), 32'd32);
        chk({tag, "_pulses"}, 32'(pulses), 32'd1);
        chk({tag, "_res"}, got, exp);
    endtask

    logic [2:0]  r_o;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int          pulses;
    int          p1;
    int          p2;
    logic [31:0] res1;
    logic [31:0] res2;

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        flush     = 1'b0;
        op        = '0;
        operand_a = '0;
        operand_b = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors
        run_op("mul",      3'd0, 32'd7,          32'hFFFF_FFFD);
        run_op("mulh",     3'd1, 32'd7,          32'hFFFF_FFFD);
        run_op("mulhu",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op("mulhsu",   3'd2, 32'hFFFF_FFFF,  32'd2);
        run_op("div",      3'd4, 32'hFFFF_FFF9,  32'd2);
        run_op("rem",      3'd6, 32'hFFFF_FFF9,  32'd2);
        run_op("divu",     3'd5, 32'd100,        32'd7);
        run_op("remu",     3'd7, 32'd100,        32'd7);
        run_op("divu0",    3'd5, 32'd5,          32'd0);
        run_op("rem0",     3'd6, 32'd5,          32'd0);
        run_op("div0s",    3'd4, 32'hFFFF_FFF9,  32'd0);
        run_op("divovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
        run_op("removf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
        run_op("mulhmin",  3'd1, 32'h8000_0000,  32'h8000_0000);

        // Randomized ops with occasional boundary operands
        for (int i = 0; i < 40; i++) begin
            r_o = 3'($urandom);
            r_a = $urandom;
            r_b = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = 32'd0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op("rand", r_o, r_a, r_b);
        end

        // Flush at CALC cycle 10 drops the op; a new op right after is unaffected
        op = 3'd5; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_valid", 32'(result_valid), 32'd0);
        run_op("after_flush", 3'd0, 32'd123456, 32'd789);

        // Reset mid-operation clears outputs at once and yields no later result
        op = 3'd1; operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_valid", 32'(result_valid), 32'd0);
        chk("rstmid_result", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("after_rst", 3'd7, 32'd1000, 32'd33);

        // Start held high: exactly one op per accept, 34-cycle issue interval
        op = 3'd2; operand_a = 32'hFFFF_FF00; operand_b = 32'h0001_0000; start = 1'b1;
        @(posedge clk); #1;
        pulses = 0; p1 = 0; p2 = 0; res1 = '0; res2 = '0;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk); #1;
            if (k == 34) start = 1'b0;
            if (result_valid) begin
                pulses++;
                if (pulses == 1) begin p1 = k; res1 = result; end
                if (pulses == 2) begin p2 = k; res2 = result; end
            end
        end
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_first", 32'(p1), 32'd32);
        chk("b2b_interval", 32'(p2 - p1), 32'd34);
        chk("b2b_res1", res1, ref_calc(3'd2, 32'hFFFF_FF00, 32'h0001_0000));
        chk("b2b_res2", res2, ref_calc(3'd2, 32'hFFFF_FF00, 32'h0001_0000));
        chk("b2b_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
